// File: rtl/tpu_gemm_core.sv
// Output-stationary systolic GEMM engine: C[MxN] = A[MxK] * B[KxN] on an ARR x ARR PE array.
// Operands stream from the A/B buffers with per-lane skew; finished tiles are written to C one row per cycle.
module tpu_gemm_core #(
  parameter int unsigned ARR  = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 32,
  parameter int unsigned AW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            K,
  input  logic [7:0]            M,
  input  logic [7:0]            N,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  A_wr_en,
  output logic [AW-1:0]         A_index,
  input  logic [ARR*DW-1:0]     A_data_out,
  output logic                  B_wr_en,
  output logic [AW-1:0]         B_index,
  input  logic [ARR*DW-1:0]     B_data_out,
  output logic                  C_wr_en,
  output logic [AW-1:0]         C_index,
  output logic [ARR*ACCW-1:0]   C_data_in
);

  localparam int unsigned DIMW = 8;
  localparam int unsigned RW   = (ARR > 1) ? $clog2(ARR) : 1;
  localparam int unsigned DCW  = $clog2(2 * ARR);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t            state;
  logic [DIMW-1:0]   k_q, m_q, n_q, mt, nt, kcnt;
  logic [DIMW:0]     mt_tot, nt_tot;
  logic              sm_q, rd_vld, clr_acc;
  logic [DCW-1:0]    dcnt;
  logic [RW-1:0]     wcnt;

  logic [AW-1:0]        row_base, col_base, w_next, c_idx_nxt;
  logic [RW-1:0]        wsel;
  logic                 last_row;
  logic [DIMW:0]        mt_inc, nt_inc, mt_tot_c, nt_tot_c;
  logic [ARR*ACCW-1:0]  c_word;

  logic [DW-1:0]   a_in   [ARR];
  logic [DW-1:0]   b_in   [ARR];
  logic [DW-1:0]   a_edge [ARR];
  logic [DW-1:0]   b_edge [ARR];
  logic [DW-1:0]   a_fwd  [ARR][ARR-1];
  logic [DW-1:0]   b_fwd  [ARR-1][ARR];
  logic [ACCW-1:0] acc_v  [ARR][ARR];

  assign A_wr_en = 1'b0;
  assign B_wr_en = 1'b0;

  assign row_base  = AW'(mt) * AW'(ARR);
  assign col_base  = AW'(nt) * AW'(ARR);
  assign wsel      = (state == S_WRITE) ? wcnt + RW'(1) : '0;
  assign w_next    = row_base + AW'(wsel);
  assign c_idx_nxt = w_next * AW'(nt_tot) + AW'(nt);
  assign last_row  = (wcnt == RW'(ARR - 1)) || (row_base + AW'(wcnt) + AW'(1) >= AW'(m_q));
  assign mt_inc    = {1'b0, mt} + (DIMW + 1)'(1);
  assign nt_inc    = {1'b0, nt} + (DIMW + 1)'(1);
  assign mt_tot_c  = ({1'b0, M} + (DIMW + 1)'(ARR - 1)) / (DIMW + 1)'(ARR);
  assign nt_tot_c  = ({1'b0, N} + (DIMW + 1)'(ARR - 1)) / (DIMW + 1)'(ARR);

  // Lane split (lane 0 in the MSBs) with edge-tile masking; zeros when no read is returning
  always_comb begin
    for (int i = 0; i < ARR; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      if (rd_vld && (row_base + AW'(i) < AW'(m_q))) a_in[i] = A_data_out[(ARR-1-i)*DW +: DW];
      if (rd_vld && (col_base + AW'(i) < AW'(n_q))) b_in[i] = B_data_out[(ARR-1-i)*DW +: DW];
    end
  end

  // Next C word: tile row wsel, columns past N forced to zero
  always_comb begin
    c_word = '0;
    for (int j = 0; j < ARR; j++) begin
      if (col_base + AW'(j) < AW'(n_q)) c_word[(ARR-1-j)*ACCW +: ACCW] = acc_v[wsel][j];
    end
  end

  for (genvar i = 0; i < ARR; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_edge[0] = a_in[0];
      assign b_edge[0] = b_in[0];
    end else begin : g_delay
      logic [DW-1:0] a_sr [i];
      logic [DW-1:0] b_sr [i];
      always_ff @(posedge clk) begin
        if (rst || clr_acc) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_in[i];
          b_sr[0] <= b_in[i];
          for (int s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  // PE(i,j): A flows right, B flows down, accumulator stays put
  for (genvar i = 0; i < ARR; i++) begin : g_row
    for (genvar j = 0; j < ARR; j++) begin : g_col
      logic [DW-1:0]   a_l, b_u;
      logic [ACCW-1:0] a_x, b_x, acc_q;

      if (j == 0) begin : g_al_edge
        assign a_l = a_edge[i];
      end else begin : g_al_fwd
        assign a_l = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_bu_edge
        assign b_u = b_edge[j];
      end else begin : g_bu_fwd
        assign b_u = b_fwd[i-1][j];
      end

      assign a_x = {{(ACCW-DW){sm_q & a_l[DW-1]}}, a_l};
      assign b_x = {{(ACCW-DW){sm_q & b_u[DW-1]}}, b_u};

      always_ff @(posedge clk) begin
        if (rst || clr_acc) acc_q <= '0;
        else                acc_q <= acc_q + a_x * b_x;
      end
      assign acc_v[i][j] = acc_q;

      if (j < ARR - 1) begin : g_apass
        logic [DW-1:0] a_q;
        always_ff @(posedge clk) begin
          if (rst || clr_acc) a_q <= '0;
          else                a_q <= a_l;
        end
        assign a_fwd[i][j] = a_q;
      end
      if (i < ARR - 1) begin : g_bpass
        logic [DW-1:0] b_q;
        always_ff @(posedge clk) begin
          if (rst || clr_acc) b_q <= '0;
          else                b_q <= b_u;
        end
        assign b_fwd[i][j] = b_q;
      end
    end
  end

  // Job sequencer: tiles mt-major, then nt; all buffer-side outputs registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      k_q       <= '0;
      m_q       <= '0;
      n_q       <= '0;
      sm_q      <= 1'b0;
      mt_tot    <= '0;
      nt_tot    <= '0;
      mt        <= '0;
      nt        <= '0;
      kcnt      <= '0;
      dcnt      <= '0;
      wcnt      <= '0;
      rd_vld    <= 1'b0;
      clr_acc   <= 1'b0;
      A_index   <= '0;
      B_index   <= '0;
      C_wr_en   <= 1'b0;
      C_index   <= '0;
      C_data_in <= '0;
    end else begin
      rd_vld  <= (state == S_FEED);
      clr_acc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            k_q    <= K;
            m_q    <= M;
            n_q    <= N;
            sm_q   <= signed_mode;
            mt_tot <= mt_tot_c;
            nt_tot <= nt_tot_c;
            mt     <= '0;
            nt     <= '0;
            kcnt   <= '0;
            busy   <= 1'b1;
            if (K == '0 || M == '0 || N == '0) begin
              state <= S_DONE;
            end else begin
              state   <= S_FEED;
              clr_acc <= 1'b1;
              A_index <= '0;
              B_index <= '0;
            end
          end
        end
        S_FEED: begin
          if (kcnt == k_q - DIMW'(1)) begin
            state <= S_DRAIN;
            dcnt  <= '0;
          end else begin
            kcnt    <= kcnt + DIMW'(1);
            A_index <= A_index + AW'(1);
            B_index <= B_index + AW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt == DCW'(2 * ARR - 2)) begin
            state     <= S_WRITE;
            wcnt      <= '0;
            C_wr_en   <= 1'b1;
            C_index   <= c_idx_nxt;
            C_data_in <= c_word;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        S_WRITE: begin
          if (!last_row) begin
            wcnt      <= wcnt + RW'(1);
            C_index   <= c_idx_nxt;
            C_data_in <= c_word;
          end else begin
            C_wr_en <= 1'b0;
            kcnt    <= '0;
            if (nt_inc < nt_tot) begin
              nt      <= nt_inc[DIMW-1:0];
              A_index <= AW'(mt) * AW'(k_q);
              B_index <= AW'(nt_inc) * AW'(k_q);
              clr_acc <= 1'b1;
              state   <= S_FEED;
            end else if (mt_inc < mt_tot) begin
              mt      <= mt_inc[DIMW-1:0];
              nt      <= '0;
              A_index <= AW'(mt_inc) * AW'(k_q);
              B_index <= '0;
              clr_acc <= 1'b1;
              state   <= S_FEED;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
